// File: rtl/idct_pkg.sv
// Shared constants, FSM encoding and index types for the 8x8 integer IDCT engine.
package idct_pkg;

  localparam int N       = 8;
  localparam int COEF_W  = 16;
  localparam int PIX_W   = 16;
  localparam int ACC_W   = 40;
  localparam int Q_SHIFT = 18;
  localparam int CQ_W    = 10;
  localparam int B_W     = 18;
  localparam int TERM_W  = COEF_W + B_W;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  typedef logic [5:0] idx_t;    // raster index into the 8x8 block
  typedef logic [2:0] coord_t;  // row or column coordinate

endpackage

// File: rtl/idct_8x8_engine_if.sv
// Coefficient-in / sample-out handshake bundle for idct_8x8_engine.
interface idct_8x8_engine_if;
  import idct_pkg::*;

  logic                     coef_valid;
  logic                     coef_ready;
  logic signed [COEF_W-1:0] coef_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic signed [PIX_W-1:0]  pix_data;
  logic                     pix_last;
  logic                     busy;

  modport master (
    output coef_valid, coef_data, pix_ready,
    input  coef_ready, pix_valid, pix_data, pix_last, busy
  );

  modport slave (
    input  coef_valid, coef_data, pix_ready,
    output coef_ready, pix_valid, pix_data, pix_last, busy
  );

endinterface

// File: rtl/idct_cos_rom.sv
// Combinational Q8 cosine basis: cq(k,n) = round(256 * C(k) * cos((2n+1)k*pi/16)).
module idct_cos_rom
  import idct_pkg::*;
(
  input  coord_t                 k,
  input  coord_t                 n,
  output logic signed [CQ_W-1:0] cq
);

  logic [4:0] phase;

  // First-quadrant magnitudes of 256*cos(i*pi/16), i = 0..8.
  function automatic logic signed [CQ_W-1:0] base(input logic [4:0] i);
    case (i)
      5'd0:    return 10'sd256;
      5'd1:    return 10'sd251;
      5'd2:    return 10'sd237;
      5'd3:    return 10'sd213;
      5'd4:    return 10'sd181;
      5'd5:    return 10'sd142;
      5'd6:    return 10'sd98;
      5'd7:    return 10'sd50;
      default: return 10'sd0;
    endcase
  endfunction

  // Angle in units of pi/16, reduced mod 32 (one full turn).
  assign phase = {1'b0, n, 1'b1} * {2'b00, k};

  always_comb begin
    if (k == 3'd0)           cq = 10'sd181;
    else if (phase <= 5'd8)  cq = base(phase);
    else if (phase <= 5'd16) cq = -base(5'd16 - phase);
    else if (phase <= 5'd24) cq = -base(phase - 5'd16);
    else                     cq = base(5'd0 - phase);
  end

endmodule

// File: rtl/idct_8x8_engine.sv
// 8x8 direct-form IDCT: load 64 coefficients, then one 64-term MAC pass per output sample.
// Optional IDCT_CLAMP_EN saturates each sample to [-128, 127].
module idct_8x8_engine
  import idct_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  idct_8x8_engine_if.slave  bus
);

  localparam logic [1:0] S_LOAD    = ST_LOAD;
  localparam logic [1:0] S_COMPUTE = ST_COMPUTE;
  localparam logic [1:0] S_OUTPUT  = ST_OUTPUT;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (Q_SHIFT - 1);

  logic [1:0]               state;
  idx_t                     idx, m, p;
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] coef_buf [N*N];

  logic signed [CQ_W-1:0]   row_cq, col_cq;
  logic signed [B_W-1:0]    b;
  logic signed [TERM_W-1:0] term;
  logic signed [ACC_W-1:0]  shifted;

  idct_cos_rom u_row_rom (.k(m[5:3]), .n(p[5:3]), .cq(row_cq));
  idct_cos_rom u_col_rom (.k(m[2:0]), .n(p[2:0]), .cq(col_cq));

  assign b    = B_W'(row_cq) * B_W'(col_cq);
  assign term = coef_buf[m] * b;

  // NOTE: the coefficient store has no reset term; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (bus.coef_valid && state == S_LOAD) coef_buf[idx] <= bus.coef_data;
  end

  // NOTE: all state below updates with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      idx   <= '0;
      m     <= '0;
      p     <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_LOAD: if (bus.coef_valid) begin
          idx <= idx + 6'd1;
          if (idx == 6'd63) begin
            state <= S_COMPUTE;
            p     <= '0;
            m     <= '0;
          end
        end
        S_COMPUTE: begin
          acc <= (m == 6'd0) ? {{(ACC_W-TERM_W){term[TERM_W-1]}}, term}
                             : acc + {{(ACC_W-TERM_W){term[TERM_W-1]}}, term};
          m   <= m + 6'd1;
          if (m == 6'd63) state <= S_OUTPUT;
        end
        S_OUTPUT: if (bus.pix_ready) begin
          if (p == 6'd63) begin
            state <= S_LOAD;
          end else begin
            p     <= p + 6'd1;
            state <= S_COMPUTE;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign shifted = (acc + RND) >>> Q_SHIFT;

  // NOTE: both branches assign pix_data on every path, so no latch is inferred.
  always_comb begin
`ifdef IDCT_CLAMP_EN
    if (shifted > 127)       bus.pix_data = 16'sd127;
    else if (shifted < -128) bus.pix_data = -16'sd128;
    else                     bus.pix_data = PIX_W'(shifted);
`else
    bus.pix_data = PIX_W'(shifted);
`endif
  end

  assign bus.coef_ready = (state == S_LOAD);
  assign bus.pix_valid  = (state == S_OUTPUT);
  assign bus.pix_last   = (state == S_OUTPUT) && (p == 6'd63);
  assign bus.busy       = (state != S_LOAD);

endmodule
